// File: rtl/lcd_pkg.sv
// lcd_pkg
//   Shared definitions for the CPU result display on a 16x2 HD44780 LCD:
//   controller command bytes, ASCII codes, the FSM state encodings and the
//   helpers that turn a captured (opcode, index, value) into display bytes.
//   No ports; imported by lcd_bus_writer and lcd_result_display.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_ONE   = 8'h31;
  localparam logic [7:0] ASCII_R     = 8'h52;

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_INIT_FUNC,
    ST_INIT_DISP,
    ST_INIT_CLEAR,
    ST_INIT_ENTRY,
    ST_IDLE,
    ST_L1_ADDR,
    ST_L1_CHARS,
    ST_L2_ADDR,
    ST_L2_CHARS
  } main_state_t;

  typedef enum logic [1:0] {
    BW_IDLE,
    BW_SETUP,
    BW_PULSE,
    BW_WAIT
  } bw_state_t;

  // One character of the 4-letter mnemonic, leftmost first.
  function automatic logic [7:0] mnemonic_char(input logic [2:0] opcode,
                                               input logic [1:0] pos);
    logic [31:0] text;
    case (opcode)
      3'd0:    text = "LOAD";
      3'd1:    text = "ADD ";
      3'd2:    text = "ADDI";
      3'd3:    text = "SUB ";
      3'd4:    text = "SUBI";
      3'd5:    text = "MUL ";
      3'd6:    text = "CLR ";
      default: text = "DPL ";
    endcase
    case (pos)
      2'd0:    return text[31:24];
      2'd1:    return text[23:16];
      2'd2:    return text[15:8];
      default: return text[7:0];
    endcase
  endfunction

  // Line 1 layout: "MNEM Rdd" followed by eight blanks.
  function automatic logic [7:0] line1_char(input logic [2:0] opcode,
                                            input logic [3:0] reg_index,
                                            input logic [3:0] pos);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = (reg_index >= 4'd10) ? 4'd1 : 4'd0;
    ones = (reg_index >= 4'd10) ? (reg_index - 4'd10) : reg_index;
    case (pos)
      4'd0, 4'd1, 4'd2, 4'd3: return mnemonic_char(opcode, pos[1:0]);
      4'd5:                   return ASCII_R;
      4'd6:                   return ASCII_ZERO + {4'd0, tens};
      4'd7:                   return ASCII_ZERO + {4'd0, ones};
      default:                return ASCII_SPACE;
    endcase
  endfunction

  // Line 2 layout: the value in binary, MSB in the leftmost column.
  function automatic logic [7:0] line2_char(input logic [15:0] value,
                                            input logic [3:0] pos);
    return value[4'd15 - pos] ? ASCII_ONE : ASCII_ZERO;
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer
//   Performs one HD44780 byte write: SETUP (1 clk, EN low) -> PULSE
//   (EN_CYCLES clk, EN high) -> WAIT (CHAR_WAIT or CLEAR_WAIT clk, EN low).
//   RS/DATA are latched on start and held until the next start.
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   start             accept rs/data/long_wait (only honoured when idle)
//   rs, data          register select and byte to write
//   long_wait         use CLEAR_WAIT instead of CHAR_WAIT after the pulse
//   done              one-cycle pulse on the last WAIT clock
//   lcd_data, lcd_rs, lcd_en   LCD bus pins
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES  = 25,
  parameter int CHAR_WAIT  = 2500,
  parameter int CLEAR_WAIT = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en
);

  localparam int MAX_A   = (EN_CYCLES > CHAR_WAIT) ? EN_CYCLES : CHAR_WAIT;
  localparam int MAX_CYC = (MAX_A > CLEAR_WAIT) ? MAX_A : CLEAR_WAIT;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  bw_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             long_q, long_d;
  logic [CNT_W-1:0] wait_last;

  assign wait_last = long_q ? CNT_W'(CLEAR_WAIT - 1) : CNT_W'(CHAR_WAIT - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BW_IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    long_d  = long_q;
    case (state_q)
      BW_IDLE: begin
        if (start) begin
          state_d = BW_SETUP;
          cnt_d   = '0;
          data_d  = data;
          rs_d    = rs;
          long_d  = long_wait;
        end
      end
      BW_SETUP: begin
        state_d = BW_PULSE;
        cnt_d   = '0;
      end
      BW_PULSE: begin
        if (cnt_q == CNT_W'(EN_CYCLES - 1)) begin
          state_d = BW_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == wait_last) begin
          state_d = BW_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // EN is decoded from the state register so a reset drops it on the next edge.
  always_comb begin
    lcd_data = data_q;
    lcd_rs   = rs_q;
    lcd_en   = (state_q == BW_PULSE);
    done     = (state_q == BW_WAIT) && (cnt_q == wait_last);
  end

endmodule

// File: rtl/lcd_result_display.sv
// lcd_result_display
//   Captures opcode / destination index / result on each rising edge of
//   update_in and renders them on a 16x2 HD44780 LCD after power-up init.
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   opcode_in[2:0]        operation to show as a mnemonic
//   reg_index_in[3:0]     destination register, shown as two decimal digits
//   reg_value_in[15:0]    result, shown as 16 binary digits
//   update_in             request level; each rising edge is one request
//   LCD_DATA/RS/RW/EN     LCD bus (RW tied low)
//   LCD_ON, LCD_BLON      panel power and backlight, always on
//   inicializado          init sequence complete
//   busy                  init or refresh in progress
module lcd_result_display
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES = 750000,
  parameter int EN_CYCLES      = 25,
  parameter int CHAR_WAIT      = 2500,
  parameter int CLEAR_WAIT     = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  opcode_in,
  input  logic [3:0]  reg_index_in,
  input  logic [15:0] reg_value_in,
  input  logic        update_in,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_ON,
  output logic        LCD_BLON,
  output logic        inicializado,
  output logic        busy
);

  localparam int PWR_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;

  main_state_t      state_q, state_d;
  logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic             active_q, active_d;
  logic [4:0]       char_idx_q, char_idx_d;
  logic             update_q, update_d;
  logic             pending_q, pending_d;
  logic [2:0]       op_q, op_d, snap_op_q, snap_op_d;
  logic [3:0]       idx_q, idx_d, snap_idx_q, snap_idx_d;
  logic [15:0]      val_q, val_d, snap_val_q, snap_val_d;

  logic       rise;
  logic       wr_start, wr_rs, wr_long, wr_done;
  logic [7:0] wr_data;

  assign rise = update_in & ~update_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_PWR_WAIT;
      pwr_cnt_q  <= '0;
      active_q   <= 1'b0;
      char_idx_q <= 5'd0;
      update_q   <= 1'b0;
      pending_q  <= 1'b0;
      op_q       <= 3'd0;
      idx_q      <= 4'd0;
      val_q      <= 16'h0000;
      snap_op_q  <= 3'd0;
      snap_idx_q <= 4'd0;
      snap_val_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      active_q   <= active_d;
      char_idx_q <= char_idx_d;
      update_q   <= update_d;
      pending_q  <= pending_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      val_q      <= val_d;
      snap_op_q  <= snap_op_d;
      snap_idx_q <= snap_idx_d;
      snap_val_q <= snap_val_d;
    end
  end

  // Each byte state first launches a write (active goes high), then waits
  // for the writer's done pulse before moving on.
  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    active_d   = active_q;
    char_idx_d = char_idx_q;
    update_d   = update_in;
    pending_d  = pending_q;
    op_d       = op_q;
    idx_d      = idx_q;
    val_d      = val_q;
    snap_op_d  = snap_op_q;
    snap_idx_d = snap_idx_q;
    snap_val_d = snap_val_q;
    case (state_q)
      ST_PWR_WAIT: begin
        if (pwr_cnt_q == PWR_W'(POWERUP_CYCLES - 1)) begin
          pwr_cnt_d = '0;
          state_d   = ST_INIT_FUNC;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pending_q) begin
          pending_d  = 1'b0;
          snap_op_d  = op_q;
          snap_idx_d = idx_q;
          snap_val_d = val_q;
          char_idx_d = 5'd0;
          state_d    = ST_L1_ADDR;
        end
      end
      default: begin
        if (!active_q) begin
          active_d = 1'b1;
        end else if (wr_done) begin
          active_d = 1'b0;
          case (state_q)
            ST_INIT_FUNC:  state_d = ST_INIT_DISP;
            ST_INIT_DISP:  state_d = ST_INIT_CLEAR;
            ST_INIT_CLEAR: state_d = ST_INIT_ENTRY;
            ST_INIT_ENTRY: state_d = ST_IDLE;
            ST_L1_ADDR:    state_d = ST_L1_CHARS;
            ST_L2_ADDR:    state_d = ST_L2_CHARS;
            ST_L1_CHARS, ST_L2_CHARS: begin
              if (char_idx_q == 5'd15) begin
                char_idx_d = 5'd0;
                state_d    = (state_q == ST_L1_CHARS) ? ST_L2_ADDR : ST_IDLE;
              end else begin
                char_idx_d = char_idx_q + 5'd1;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase
    // Capture wins over consumption so a request arriving the same cycle
    // the FSM leaves IDLE still gets its own refresh.
    if (rise) begin
      op_d      = opcode_in;
      idx_d     = reg_index_in;
      val_d     = reg_value_in;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    wr_rs        = 1'b0;
    wr_data      = 8'h00;
    wr_long      = 1'b0;
    wr_start     = 1'b0;
    inicializado = 1'b1;
    busy         = 1'b1;
    case (state_q)
      ST_PWR_WAIT: begin
        inicializado = 1'b0;
      end
      ST_INIT_FUNC: begin
        inicializado = 1'b0;
        wr_data      = CMD_FUNC_SET;
        wr_start     = !active_q;
      end
      ST_INIT_DISP: begin
        inicializado = 1'b0;
        wr_data      = CMD_DISP_ON;
        wr_start     = !active_q;
      end
      ST_INIT_CLEAR: begin
        inicializado = 1'b0;
        wr_data      = CMD_CLEAR;
        wr_long      = 1'b1;
        wr_start     = !active_q;
      end
      ST_INIT_ENTRY: begin
        inicializado = 1'b0;
        wr_data      = CMD_ENTRY;
        wr_start     = !active_q;
      end
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_L1_ADDR: begin
        wr_data  = CMD_LINE1;
        wr_start = !active_q;
      end
      ST_L1_CHARS: begin
        wr_rs    = 1'b1;
        wr_data  = line1_char(snap_op_q, snap_idx_q, char_idx_q[3:0]);
        wr_start = !active_q;
      end
      ST_L2_ADDR: begin
        wr_data  = CMD_LINE2;
        wr_start = !active_q;
      end
      ST_L2_CHARS: begin
        wr_rs    = 1'b1;
        wr_data  = line2_char(snap_val_q, char_idx_q[3:0]);
        wr_start = !active_q;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  lcd_bus_writer #(
    .EN_CYCLES  (EN_CYCLES),
    .CHAR_WAIT  (CHAR_WAIT),
    .CLEAR_WAIT (CLEAR_WAIT)
  ) u_writer (
    .clock     (clock),
    .reset     (reset),
    .start     (wr_start),
    .rs        (wr_rs),
    .data      (wr_data),
    .long_wait (wr_long),
    .done      (wr_done),
    .lcd_data  (LCD_DATA),
    .lcd_rs    (LCD_RS),
    .lcd_en    (LCD_EN)
  );

  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

endmodule

// File: tb/tb_lcd_result_display.sv
// tb_lcd_result_display
//   Directed bench for lcd_result_display with shortened timing. A bus
//   monitor records every byte written to the LCD (captured when EN rises)
//   and checks pulse width, inter-byte gap and RS/DATA stability.
module tb_lcd_result_display;

  localparam int POWERUP = 20;
  localparam int ENC     = 2;
  localparam int CHARW   = 4;
  localparam int CLEARW  = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  opcode_in = 3'd0;
  logic [3:0]  reg_index_in = 4'd0;
  logic [15:0] reg_value_in = 16'h0000;
  logic        update_in = 1'b0;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;
  logic        inicializado, busy;

  int vec_count  = 0;
  int fail_count = 0;
  logic [8:0] bytes_q[$];

  lcd_result_display #(
    .POWERUP_CYCLES (POWERUP),
    .EN_CYCLES      (ENC),
    .CHAR_WAIT      (CHARW),
    .CLEAR_WAIT     (CLEARW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .opcode_in    (opcode_in),
    .reg_index_in (reg_index_in),
    .reg_value_in (reg_value_in),
    .update_in    (update_in),
    .LCD_DATA     (LCD_DATA),
    .LCD_RS       (LCD_RS),
    .LCD_RW       (LCD_RW),
    .LCD_EN       (LCD_EN),
    .LCD_ON       (LCD_ON),
    .LCD_BLON     (LCD_BLON),
    .inicializado (inicializado),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vec_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [3:0] idx,
                                input logic [15:0] val, input logic upd);
    opcode_in    = op;
    reg_index_in = idx;
    reg_value_in = val;
    update_in    = upd;
    @(posedge clock); #1;
  endtask

  // Returns once busy has been low for several consecutive cycles.
  task automatic wait_idle(input string tag, input int budget);
    int steady = 0;
    int n = 0;
    while (steady < 4 && n < budget) begin
      @(posedge clock); #1;
      n++;
      if (!busy && inicializado) steady++;
      else steady = 0;
    end
    check_output({tag, "_idle_reached"}, 32'(steady >= 4), 32'd1);
  endtask

  task automatic check_init(input string tag, input int base);
    check_output({tag, "_b0"}, 32'(bytes_q[base]),     32'h038);
    check_output({tag, "_b1"}, 32'(bytes_q[base + 1]), 32'h00C);
    check_output({tag, "_b2"}, 32'(bytes_q[base + 2]), 32'h001);
    check_output({tag, "_b3"}, 32'(bytes_q[base + 3]), 32'h006);
  endtask

  task automatic check_refresh(input string tag, input int base,
                               input string l1, input string l2);
    check_output({tag, "_line1_cmd"}, 32'(bytes_q[base]), 32'h080);
    for (int i = 0; i < 16; i++)
      check_output($sformatf("%s_l1_%0d", tag, i), 32'(bytes_q[base + 1 + i]),
                   32'({1'b1, l1[i]}));
    check_output({tag, "_line2_cmd"}, 32'(bytes_q[base + 17]), 32'h0C0);
    for (int i = 0; i < 16; i++)
      check_output($sformatf("%s_l2_%0d", tag, i), 32'(bytes_q[base + 18 + i]),
                   32'({1'b1, l2[i]}));
  endtask

  // Bus monitor, sampled on the falling edge.
  logic       mon_prev_en = 1'b0;
  logic       mon_have_prev = 1'b0;
  logic       mon_in_pulse = 1'b0;
  logic       mon_last_clear = 1'b0;
  logic [8:0] mon_byte = 9'h000;
  int         mon_high = 0;
  int         mon_gap = 0;

  always @(negedge clock) begin
    if (reset) begin
      mon_prev_en   = 1'b0;
      mon_have_prev = 1'b0;
      mon_in_pulse  = 1'b0;
      mon_high      = 0;
      mon_gap       = 0;
    end else begin
      if (LCD_EN && !mon_prev_en) begin
        mon_byte = {LCD_RS, LCD_DATA};
        bytes_q.push_back(mon_byte);
        if (mon_have_prev)
          check_output("byte_gap",
                       32'((mon_gap - 1) >= (mon_last_clear ? CLEARW : CHARW)), 32'd1);
        mon_high     = 1;
        mon_in_pulse = 1'b1;
      end else if (LCD_EN) begin
        mon_high++;
        check_output("rs_data_hold", 32'({LCD_RS, LCD_DATA}), 32'(mon_byte));
      end else if (mon_prev_en && mon_in_pulse) begin
        check_output("en_width", mon_high, ENC);
        mon_have_prev  = 1'b1;
        mon_last_clear = (mon_byte == 9'h001);
        mon_gap        = 1;
        mon_in_pulse   = 1'b0;
      end else begin
        mon_gap++;
      end
      mon_prev_en = LCD_EN;
    end
  end

  initial begin
    int n;
    $display("[TB] start");

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check_output("rst_en",    32'(LCD_EN),       32'd0);
    check_output("rst_data",  32'(LCD_DATA),     32'h00);
    check_output("rst_rs",    32'(LCD_RS),       32'd0);
    check_output("rst_rw",    32'(LCD_RW),       32'd0);
    check_output("rst_on",    32'(LCD_ON),       32'd1);
    check_output("rst_blon",  32'(LCD_BLON),     32'd1);
    check_output("rst_init",  32'(inicializado), 32'd0);
    check_output("rst_busy",  32'(busy),         32'd1);

    // Init sequence
    reset = 1'b0;
    bytes_q.delete();
    wait_idle("init", 500);
    check_output("init_count", bytes_q.size(), 4);
    check_init("init", 0);
    check_output("init_done", 32'(inicializado), 32'd1);
    check_output("init_busy", 32'(busy),         32'd0);

    // Single refresh
    bytes_q.delete();
    apply_stimulus(3'b010, 4'd7, 16'h00A5, 1'b1);
    wait_idle("ref1", 1000);
    check_output("ref1_count", bytes_q.size(), 34);
    check_refresh("ref1", 0, "ADDI R07        ", "0000000010100101");

    // Held level: no repeat
    bytes_q.delete();
    repeat (200) @(posedge clock);
    #1;
    check_output("held_count", bytes_q.size(), 0);
    check_output("held_busy",  32'(busy), 32'd0);

    // Two requests while the first refresh runs
    apply_stimulus(3'b010, 4'd7, 16'h00A5, 1'b0);
    bytes_q.delete();
    apply_stimulus(3'b010, 4'd7, 16'hFFFF, 1'b1);
    repeat (30) @(posedge clock);
    #1;
    check_output("mid_busy", 32'(busy), 32'd1);
    apply_stimulus(3'b010, 4'd7, 16'hFFFF, 1'b0);
    apply_stimulus(3'b101, 4'd12, 16'h0001, 1'b1);
    wait_idle("ref2", 3000);
    check_output("ref2_count", bytes_q.size(), 68);
    check_refresh("ref2a", 0,  "ADDI R07        ", "1111111111111111");
    check_refresh("ref2b", 34, "MUL  R12        ", "0000000000000001");

    // Reset in the middle of an EN pulse
    apply_stimulus(3'b101, 4'd12, 16'h0001, 1'b0);
    bytes_q.delete();
    apply_stimulus(3'b000, 4'd15, 16'h1234, 1'b1);
    n = 0;
    while (!(LCD_EN && bytes_q.size() >= 5) && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    check_output("mid_pulse_found", 32'(LCD_EN && bytes_q.size() >= 5), 32'd1);
    reset     = 1'b1;
    update_in = 1'b0;
    @(posedge clock); #1;
    check_output("mrst_en",   32'(LCD_EN),       32'd0);
    check_output("mrst_init", 32'(inicializado), 32'd0);
    check_output("mrst_busy", 32'(busy),         32'd1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    bytes_q.delete();
    repeat (5) @(posedge clock);
    #1;
    check_output("pre_init_state", 32'(inicializado), 32'd0);
    apply_stimulus(3'b110, 4'd3, 16'h8000, 1'b1);
    wait_idle("reinit", 2000);
    check_output("reinit_count", bytes_q.size(), 38);
    check_init("reinit", 0);
    check_refresh("ref3", 4, "CLR  R03        ", "1000000000000000");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
